// File: rtl/vga_fetch_pkg.sv
// Shared types and defaults for the VGA framebuffer word fetcher.
package vga_fetch_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned COUNT_W = 17;  // holds FRAME_WORDS up to 65536
  localparam int unsigned LEVEL_W = 5;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR   = 16'hC000;
  localparam int unsigned       DEFAULT_FRAME_WORDS = 4800;
  localparam int unsigned       DEFAULT_FIFO_DEPTH  = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/vga_word_fetcher_if.sv
// Memory port B and pixel-side word stream of the framebuffer fetcher.
interface vga_word_fetcher_if;
  import vga_fetch_pkg::*;

  logic               frame_start;
  addr_t              mem_address;
  logic               mem_write_enable;
  word_t              mem_write_data;
  word_t              mem_read_data;
  logic               word_valid;
  word_t              word_data;
  logic               word_ready;
  logic [LEVEL_W-1:0] fifo_level;
  logic               underflow;
  logic               frame_done;

  modport master (
    input  frame_start, mem_read_data, word_ready,
    output mem_address, mem_write_enable, mem_write_data,
           word_valid, word_data, fifo_level, underflow, frame_done
  );

  modport slave (
    output frame_start, mem_read_data, word_ready,
    input  mem_address, mem_write_enable, mem_write_data,
           word_valid, word_data, fifo_level, underflow, frame_done
  );

endinterface

// File: rtl/vga_word_fetcher_sync_fifo.sv
// Synchronous FIFO with flush, occupancy output and simultaneous push/pop.
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && ((level != (PTR_W+1)'(DEPTH)) || do_pop);
  assign head    = store[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // data storage, contents need no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_word_fetcher.sv
// Streams a frame of framebuffer words from memory port B into a FIFO for the VGA pipeline.
module vga_word_fetcher
  import vga_fetch_pkg::*;
#(
  parameter addr_t       BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned FRAME_WORDS = DEFAULT_FRAME_WORDS,
  parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input logic               clock,
  input logic               reset_n,
  vga_word_fetcher_if.master bus
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e       state;
  fetch_state_e       state_nxt;
  logic [COUNT_W-1:0] issued_count;
  addr_t              mem_addr_q;
  logic               in_flight;
  logic               issue;
  logic               underflow_q;
  logic               frame_done_q;
  logic [LVL_W-1:0]   level;
  word_t              head;
  logic               fifo_empty;

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state and read-issue decision; in-flight reads are counted so a push never meets a full FIFO
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    if (bus.frame_start) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE: ;
        FETCH: begin
          if (((32'(level) + 32'(in_flight)) < FIFO_DEPTH) && (32'(issued_count) < FRAME_WORDS)) begin
            issue = 1'b1;
            if (32'(issued_count) == FRAME_WORDS - 1) state_nxt = DRAIN;
          end
        end
        DRAIN:   if (in_flight) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // address register, issue counter and one-deep read pipeline
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_count <= '0;
      in_flight    <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
    end else if (bus.frame_start) begin
      issued_count <= '0;
      in_flight    <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        mem_addr_q   <= BASE_ADDR + issued_count[ADDR_W-1:0];
        issued_count <= issued_count + 1'b1;
      end
    end
  end

  // sticky underflow and end-of-frame pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= !bus.frame_start && (state == DRAIN) && in_flight;
      if (bus.frame_start)
        underflow_q <= 1'b0;
      else if ((state != IDLE) && bus.word_ready && fifo_empty)
        underflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset_n),
    .flush     (bus.frame_start),
    .push      (in_flight && !bus.frame_start),
    .push_data (bus.mem_read_data),
    .pop       (bus.word_ready),
    .head      (head),
    .level     (level),
    .empty     (fifo_empty)
  );

  assign bus.mem_address      = mem_addr_q;
  assign bus.mem_write_enable = 1'b0;
  assign bus.mem_write_data   = '0;
  assign bus.word_valid       = !fifo_empty;
  assign bus.word_data        = head;
  assign bus.fifo_level       = LEVEL_W'(level);
  assign bus.underflow        = underflow_q;
  assign bus.frame_done       = frame_done_q;

endmodule

// File: tb/tb_vga_word_fetcher.sv
// Self-checking bench for vga_word_fetcher: three instances with different base/length,
// a port-B memory model holding mem[i]=i, and an in-order word reference model.
module tb_vga_word_fetcher;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic        fs  [3];
  logic        rdy [3];
  logic        vld [3];
  logic [15:0] dat [3];
  logic [4:0]  lvl [3];
  logic        unf [3];
  logic        fdn [3];
  logic [15:0] adr [3];
  logic        wen [3];

  logic [15:0] mem_model [65536];

  vga_word_fetcher_if if_a ();
  vga_word_fetcher_if if_b ();
  vga_word_fetcher_if if_c ();

  vga_word_fetcher #(.BASE_ADDR(16'hC000), .FRAME_WORDS(8), .FIFO_DEPTH(16)) u_a (
    .clock(clock), .reset_n(reset_n), .bus(if_a.master));
  vga_word_fetcher #(.BASE_ADDR(16'hC000), .FRAME_WORDS(40), .FIFO_DEPTH(16)) u_b (
    .clock(clock), .reset_n(reset_n), .bus(if_b.master));
  vga_word_fetcher #(.BASE_ADDR(16'hFFFE), .FRAME_WORDS(4), .FIFO_DEPTH(16)) u_c (
    .clock(clock), .reset_n(reset_n), .bus(if_c.master));

  assign if_a.frame_start = fs[0];
  assign if_b.frame_start = fs[1];
  assign if_c.frame_start = fs[2];
  assign if_a.word_ready  = rdy[0];
  assign if_b.word_ready  = rdy[1];
  assign if_c.word_ready  = rdy[2];

  assign vld[0] = if_a.word_valid;  assign vld[1] = if_b.word_valid;  assign vld[2] = if_c.word_valid;
  assign dat[0] = if_a.word_data;   assign dat[1] = if_b.word_data;   assign dat[2] = if_c.word_data;
  assign lvl[0] = if_a.fifo_level;  assign lvl[1] = if_b.fifo_level;  assign lvl[2] = if_c.fifo_level;
  assign unf[0] = if_a.underflow;   assign unf[1] = if_b.underflow;   assign unf[2] = if_c.underflow;
  assign fdn[0] = if_a.frame_done;  assign fdn[1] = if_b.frame_done;  assign fdn[2] = if_c.frame_done;
  assign adr[0] = if_a.mem_address; assign adr[1] = if_b.mem_address; assign adr[2] = if_c.mem_address;
  assign wen[0] = if_a.mem_write_enable | (|if_a.mem_write_data);
  assign wen[1] = if_b.mem_write_enable | (|if_b.mem_write_data);
  assign wen[2] = if_c.mem_write_enable | (|if_c.mem_write_data);

  // port B memory: samples the address on the falling edge
  always @(negedge clock) begin
    if_a.mem_read_data <= mem_model[if_a.mem_address];
    if_b.mem_read_data <= mem_model[if_b.mem_address];
    if_c.mem_read_data <= mem_model[if_c.mem_address];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expected i-th word of a frame: mem[(base + i) mod 2^16] with mem[a] = a
  function automatic logic [15:0] exp_word(input logic [15:0] base, input int idx);
    logic [15:0] a;
    a = base + 16'(idx);
    return a;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin fs[k] = 1'b0; rdy[k] = 1'b0; end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      logic [15:0] b;
      b = (k == 2) ? 16'hFFFE : 16'hC000;
      checks++; if (vld[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b want 0", k, vld[k]); end
      checks++; if (lvl[k] !== 5'd0) begin errors++; $display("FAIL reset_level[%0d] got %0d want 0", k, lvl[k]); end
      checks++; if (unf[k] !== 1'b0) begin errors++; $display("FAIL reset_underflow[%0d] got %b want 0", k, unf[k]); end
      checks++; if (fdn[k] !== 1'b0) begin errors++; $display("FAIL reset_frame_done[%0d] got %b want 0", k, fdn[k]); end
      checks++; if (adr[k] !== b) begin errors++; $display("FAIL reset_address[%0d] got %h want %h", k, adr[k], b); end
      checks++; if (wen[k] !== 1'b0) begin errors++; $display("FAIL write_port_idle[%0d] got %b want 0", k, wen[k]); end
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // 8-word frame at full rate: latency, order, throughput, one frame_done, back to idle
  task automatic test_stream();
    int got = 0;
    int fd  = 0;
    fs[0] = 1'b1; rdy[0] = 1'b1;
    @(negedge clock); fs[0] = 1'b0;
    @(negedge clock);
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL first_valid_early got %b want 0", vld[0]); end
    @(negedge clock);
    checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL first_valid_latency got %b want 1", vld[0]); end
    for (int c = 0; c < 20; c++) begin
      if (c == 8) begin
        checks++; if (got !== 8) begin errors++; $display("FAIL throughput words_after_8_cycles got %0d want 8", got); end
      end
      if (fdn[0]) begin
        fd++;
        checks++; if (got + int'(lvl[0]) !== 8) begin errors++; $display("FAIL frame_done_timing pushed got %0d want 8", got + int'(lvl[0])); end
      end
      if (vld[0] && rdy[0]) begin
        checks++; if (dat[0] !== exp_word(16'hC000, got)) begin errors++; $display("FAIL stream_word[%0d] got %h want %h", got, dat[0], exp_word(16'hC000, got)); end
        got++;
      end
      @(negedge clock);
    end
    checks++; if (got !== 8) begin errors++; $display("FAIL stream_count got %0d want 8", got); end
    checks++; if (fd !== 1) begin errors++; $display("FAIL stream_frame_done_count got %0d want 1", fd); end
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", vld[0]); end
    checks++; if (adr[0] !== 16'hC007) begin errors++; $display("FAIL idle_address got %h want c007", adr[0]); end
    rdy[0] = 1'b0;
  endtask

  // 40-word frame with random consumer stalls
  task automatic test_random_ready();
    int   got = 0;
    int   fd  = 0;
    logic r;
    fs[1] = 1'b1; rdy[1] = 1'b0;
    @(negedge clock); fs[1] = 1'b0;
    for (int c = 0; c < 1000 && (got < 40 || c < 60); c++) begin
      checks++; if (lvl[1] > 5'd16) begin errors++; $display("FAIL random_level_bound got %0d want <=16", lvl[1]); end
      if (fdn[1]) fd++;
      r = 1'($urandom_range(0, 1));
      if (vld[1] && r) begin
        checks++; if (dat[1] !== exp_word(16'hC000, got)) begin errors++; $display("FAIL random_word[%0d] got %h want %h", got, dat[1], exp_word(16'hC000, got)); end
        got++;
      end
      rdy[1] = r;
      @(negedge clock);
    end
    rdy[1] = 1'b0;
    checks++; if (got !== 40) begin errors++; $display("FAIL random_count got %0d want 40", got); end
    checks++; if (fd !== 1) begin errors++; $display("FAIL random_frame_done_count got %0d want 1", fd); end
  endtask

  // consumer stalled: FIFO fills to 16 and issuing stops, then everything drains in order
  task automatic test_backpressure();
    int got = 0;
    fs[1] = 1'b1; rdy[1] = 1'b0;
    @(negedge clock); fs[1] = 1'b0;
    repeat (30) @(negedge clock);
    checks++; if (lvl[1] !== 5'd16) begin errors++; $display("FAIL bp_level_full got %0d want 16", lvl[1]); end
    checks++; if (adr[1] !== 16'hC00F) begin errors++; $display("FAIL bp_last_address got %h want c00f", adr[1]); end
    repeat (10) @(negedge clock);
    checks++; if (adr[1] !== 16'hC00F) begin errors++; $display("FAIL bp_no_more_reads got %h want c00f", adr[1]); end
    checks++; if (lvl[1] !== 5'd16) begin errors++; $display("FAIL bp_level_held got %0d want 16", lvl[1]); end
    for (int c = 0; c < 200 && got < 40; c++) begin
      if (vld[1]) begin
        checks++; if (dat[1] !== exp_word(16'hC000, got)) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", got, dat[1], exp_word(16'hC000, got)); end
        got++;
      end
      rdy[1] = 1'b1;
      @(negedge clock);
    end
    rdy[1] = 1'b0;
    checks++; if (got !== 40) begin errors++; $display("FAIL bp_count got %0d want 40", got); end
    repeat (3) @(negedge clock);
  endtask

  // base 16'hFFFE, 4 words: addresses wrap through zero
  task automatic test_wrap();
    int got = 0;
    fs[2] = 1'b1; rdy[2] = 1'b1;
    @(negedge clock); fs[2] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (vld[2] && rdy[2]) begin
        checks++; if (dat[2] !== exp_word(16'hFFFE, got)) begin errors++; $display("FAIL wrap_word[%0d] got %h want %h", got, dat[2], exp_word(16'hFFFE, got)); end
        got++;
      end
      @(negedge clock);
    end
    rdy[2] = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL wrap_count got %0d want 4", got); end
    checks++; if (adr[2] !== 16'h0001) begin errors++; $display("FAIL wrap_last_address got %h want 0001", adr[2]); end
  endtask

  // restart after 5 of 8 words: flushed FIFO, frame restarts at base, stale words never seen
  task automatic test_restart();
    int got = 0;
    int fd  = 0;
    bit restarted = 0;
    fs[0] = 1'b1; rdy[0] = 1'b1;
    @(negedge clock); fs[0] = 1'b0;
    for (int c = 0; c < 100 && !(restarted && got == 8 && c > 40); c++) begin
      if (fdn[0]) fd++;
      if (!restarted && got == 5) begin
        restarted = 1;
        got = 0;
        fs[0] = 1'b1; rdy[0] = 1'b0;
        @(negedge clock);
        fs[0] = 1'b0; rdy[0] = 1'b1;
      end else begin
        if (vld[0] && rdy[0]) begin
          checks++; if (dat[0] !== exp_word(16'hC000, got)) begin errors++; $display("FAIL restart_word[%0d] got %h want %h", got, dat[0], exp_word(16'hC000, got)); end
          got++;
        end
        @(negedge clock);
      end
    end
    rdy[0] = 1'b0;
    checks++; if (got !== 8) begin errors++; $display("FAIL restart_count got %0d want 8", got); end
    checks++; if (fd !== 1) begin errors++; $display("FAIL restart_frame_done_count got %0d want 1", fd); end
    checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL restart_no_extra_words got %b want 0", vld[0]); end
  endtask

  // underflow: set while fetching with an empty FIFO, sticky, cleared by frame_start, never in idle
  task automatic test_underflow();
    fs[1] = 1'b1; rdy[1] = 1'b1;
    @(negedge clock); fs[1] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (unf[1] !== 1'b1) begin errors++; $display("FAIL underflow_set got %b want 1", unf[1]); end
    repeat (80) @(negedge clock);
    checks++; if (unf[1] !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b want 1", unf[1]); end
    fs[1] = 1'b1; rdy[1] = 1'b0;
    @(negedge clock); fs[1] = 1'b0;
    checks++; if (unf[1] !== 1'b0) begin errors++; $display("FAIL underflow_cleared got %b want 0", unf[1]); end
    for (int c = 0; c < 150; c++) begin
      rdy[1] = vld[1];
      @(negedge clock);
    end
    checks++; if (unf[1] !== 1'b0) begin errors++; $display("FAIL underflow_clean_frame got %b want 0", unf[1]); end
    rdy[1] = 1'b1;
    repeat (10) @(negedge clock);
    checks++; if (unf[1] !== 1'b0) begin errors++; $display("FAIL underflow_in_idle got %b want 0", unf[1]); end
    rdy[1] = 1'b0;
  endtask

  // async reset mid-frame: immediate reset values, no activity until the next frame_start
  task automatic test_reset_mid();
    bit seen = 0;
    fs[1] = 1'b1; rdy[1] = 1'b0;
    @(negedge clock); fs[1] = 1'b0;
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (vld[1] !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b want 0", vld[1]); end
    checks++; if (lvl[1] !== 5'd0) begin errors++; $display("FAIL async_reset_level got %0d want 0", lvl[1]); end
    checks++; if (adr[1] !== 16'hC000) begin errors++; $display("FAIL async_reset_address got %h want c000", adr[1]); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (vld[1] !== 1'b0 || adr[1] !== 16'hC000 || lvl[1] !== 5'd0) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL post_reset_quiet got %b want 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = 16'(i);
    test_reset();
    test_stream();
    test_random_ready();
    test_backpressure();
    test_wrap();
    test_restart();
    test_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

endmodule
